fifo_ddr3_app_bridge: RTL

Downstream stage of the AXI4 line cache. It accepts the 128-bit line-granular fifo command stream (single-line write-back, multi-line read fill) and buffers it. It translates each command into Gowin DDR3 app-interface command and write-data handshakes. Read data is returned in order through a credit-protected response FIFO on the fifo rsp port.

---
 rtl/fifo_ddr3_app_bridge.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/fifo_ddr3_app_bridge.sv
// fifo_ddr3_app_bridge
// Buffers the line-granular fifo command stream and translates each command
// into Gowin DDR3 app-interface command / write-data handshakes. Read beats
// come back in order through a first-word-fall-through response FIFO whose
// free space is reserved before each read command is issued (credit rule).
// Optional feature: define FIFO_DDR3_WDT_EN to build the read watchdog that
// drives the sticky io_err_timeout flag.
//
// Handshake semantics on every valid/ready (en/rdy) pair: a transfer happens
// on a rising clk edge where both are high; while valid/en is high and
// ready/rdy is low the source holds its payload stable.
module fifo_ddr3_app_bridge #(
    parameter int CMD_DEPTH  = 4,
    parameter int RSP_DEPTH  = 8,
    parameter int WDT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         io_fifo_cmd_valid,
    output logic         io_fifo_cmd_ready,
    input  logic         io_fifo_cmd_type,
    input  logic [26:0]  io_fifo_cmd_addr,
    input  logic [5:0]   io_fifo_cmd_burst_cnt,
    input  logic [127:0] io_fifo_cmd_wt_data,
    input  logic [15:0]  io_fifo_cmd_wt_mask,
    output logic         io_fifo_rsp_valid,
    input  logic         io_fifo_rsp_ready,
    output logic [127:0] io_fifo_rsp_data,
    input  logic         app_init_calib_complete,
    output logic         app_cmd_en,
    output logic [2:0]   app_cmd,
    output logic [27:0]  app_addr,
    input  logic         app_cmd_rdy,
    output logic         app_wdata_en,
    output logic         app_wdata_end,
    output logic [127:0] app_wdata,
    output logic [15:0]  app_wdata_mask,
    input  logic         app_wdata_rdy,
    input  logic         app_rdata_valid,
    input  logic         app_rdata_end,
    input  logic [127:0] app_rdata,
    output logic         io_err_timeout
);
    localparam int CA    = $clog2(CMD_DEPTH);
    localparam int RA    = $clog2(RSP_DEPTH);
    // Entry layout: {type, line_addr[22:0], burst_cnt[5:0], data[127:0], mask[15:0]}
    localparam int CMD_W = 1 + 23 + 6 + 128 + 16;
    localparam logic [RA+1:0] RSP_LIM = (RA+2)'(RSP_DEPTH);

    typedef enum logic [1:0] {S_CALIB, S_IDLE, S_WR, S_RD} state_t;

    // ---------------- command FIFO ----------------
    logic [CMD_W-1:0] cmd_mem_q [CMD_DEPTH];
    logic [CA:0]      cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
    logic             cmd_empty, cmd_full, cmd_push, cmd_pop;
    logic [CMD_W-1:0] cmd_head;

    assign cmd_empty = (cmd_wp_q == cmd_rp_q);
    assign cmd_full  = (cmd_wp_q[CA] != cmd_rp_q[CA]) &&
                       (cmd_wp_q[CA-1:0] == cmd_rp_q[CA-1:0]);
    // Ready depends only on full: a same-cycle pop never frees a slot early.
    assign io_fifo_cmd_ready = !cmd_full;
    assign cmd_push  = io_fifo_cmd_valid && !cmd_full;
    assign cmd_head  = cmd_mem_q[cmd_rp_q[CA-1:0]];

    // Command storage write port (contents need no reset; pointers define validity).
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem_q[cmd_wp_q[CA-1:0]] <= {io_fifo_cmd_type, io_fifo_cmd_addr[26:4],
                                            io_fifo_cmd_burst_cnt, io_fifo_cmd_wt_data,
                                            io_fifo_cmd_wt_mask};
        end
    end

    // Command FIFO pointer update.
    always_comb begin
        cmd_wp_d = cmd_wp_q;
        cmd_rp_d = cmd_rp_q;
        if (cmd_push) cmd_wp_d = cmd_wp_q + 1'b1;
        if (cmd_pop)  cmd_rp_d = cmd_rp_q + 1'b1;
    end

    // ---------------- response FIFO (first-word fall-through) ----------------
    logic [127:0] rsp_mem_q [RSP_DEPTH];
    logic [RA:0]  rsp_wp_q, rsp_wp_d, rsp_rp_q, rsp_rp_d, rsp_count;
    logic         rsp_empty, rsp_full, rsp_push, rsp_pop;

    assign rsp_count = rsp_wp_q - rsp_rp_q;
    assign rsp_empty = (rsp_wp_q == rsp_rp_q);
    assign rsp_full  = (rsp_wp_q[RA] != rsp_rp_q[RA]) &&
                       (rsp_wp_q[RA-1:0] == rsp_rp_q[RA-1:0]);
    assign rsp_pop   = !rsp_empty && io_fifo_rsp_ready;
    // Credits keep the FIFO from filling; the guard only matters for stray
    // beats that arrive after a mid-burst reset.
    assign rsp_push  = app_rdata_valid && (!rsp_full || rsp_pop);
    assign io_fifo_rsp_valid = !rsp_empty;
    assign io_fifo_rsp_data  = rsp_empty ? '0 : rsp_mem_q[rsp_rp_q[RA-1:0]];

    // Response storage write port.
    always_ff @(posedge clk) begin
        if (rsp_push) rsp_mem_q[rsp_wp_q[RA-1:0]] <= app_rdata;
    end

    // Response FIFO pointer update.
    always_comb begin
        rsp_wp_d = rsp_wp_q;
        rsp_rp_d = rsp_rp_q;
        if (rsp_push) rsp_wp_d = rsp_wp_q + 1'b1;
        if (rsp_pop)  rsp_rp_d = rsp_rp_q + 1'b1;
    end

    // ---------------- command FSM and working registers ----------------
    state_t        state_q, state_d;
    logic [22:0]   line_q, line_d;
    logic [5:0]    beat_q, beat_d, burst_q, burst_d;
    logic [127:0]  wdata_q, wdata_d;
    logic [15:0]   wmask_q, wmask_d;
    logic          cmd_done_q, cmd_done_d, data_done_q, data_done_d;
    logic [RA:0]   outst_q, outst_d;
    logic          credit_ok, rd_issue;

    // Reserve response space for every beat in flight before issuing a read.
    assign credit_ok = (({1'b0, outst_q} + {1'b0, rsp_count}) < RSP_LIM);
    assign rd_issue  = (state_q == S_RD) && app_cmd_en && app_cmd_rdy;

    assign app_addr       = {2'b00, line_q, 3'b000};
    assign app_wdata      = wdata_q;
    assign app_wdata_mask = wmask_q;
    assign app_wdata_end  = app_wdata_en;

    // Next-state, working-register updates and app strobes.
    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        beat_d       = beat_q;
        burst_d      = burst_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        cmd_done_d   = cmd_done_q;
        data_done_d  = data_done_q;
        cmd_pop      = 1'b0;
        app_cmd_en   = 1'b0;
        app_wdata_en = 1'b0;
        app_cmd      = 3'b000;
        case (state_q)
            S_CALIB: begin
                if (app_init_calib_complete) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!app_init_calib_complete) begin
                    state_d = S_CALIB;
                end else if (!cmd_empty) begin
                    cmd_pop     = 1'b1;
                    line_d      = cmd_head[172:150];
                    burst_d     = cmd_head[149:144];
                    wdata_d     = cmd_head[143:16];
                    wmask_d     = cmd_head[15:0];
                    beat_d      = '0;
                    cmd_done_d  = 1'b0;
                    data_done_d = 1'b0;
                    state_d     = cmd_head[173] ? S_RD : S_WR;
                end
            end
            S_WR: begin
                // Command and data strobes retire independently.
                app_cmd_en   = !cmd_done_q;
                app_wdata_en = !data_done_q;
                cmd_done_d   = cmd_done_q  || (app_cmd_en && app_cmd_rdy);
                data_done_d  = data_done_q || (app_wdata_en && app_wdata_rdy);
                if (cmd_done_d && data_done_d) state_d = S_IDLE;
            end
            S_RD: begin
                app_cmd    = 3'b001;
                app_cmd_en = credit_ok;
                if (app_cmd_en && app_cmd_rdy) begin
                    line_d = line_q + 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == burst_q) state_d = S_IDLE;
                end
            end
            default: state_d = S_CALIB;
        endcase
    end

    // Outstanding read beats: issue and return in the same cycle cancel;
    // a return with nothing outstanding (post-reset stray) saturates at 0.
    always_comb begin
        outst_d = outst_q;
        if (rd_issue && !app_rdata_valid) begin
            outst_d = outst_q + 1'b1;
        end else if (!rd_issue && app_rdata_valid && (outst_q != '0)) begin
            outst_d = outst_q - 1'b1;
        end
    end

    // State and pointer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_CALIB;
            cmd_wp_q    <= '0;
            cmd_rp_q    <= '0;
            rsp_wp_q    <= '0;
            rsp_rp_q    <= '0;
            line_q      <= '0;
            beat_q      <= '0;
            burst_q     <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            cmd_done_q  <= 1'b0;
            data_done_q <= 1'b0;
            outst_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_wp_q    <= cmd_wp_d;
            cmd_rp_q    <= cmd_rp_d;
            rsp_wp_q    <= rsp_wp_d;
            rsp_rp_q    <= rsp_rp_d;
            line_q      <= line_d;
            beat_q      <= beat_d;
            burst_q     <= burst_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            cmd_done_q  <= cmd_done_d;
            data_done_q <= data_done_d;
            outst_q     <= outst_d;
        end
    end

`ifdef FIFO_DDR3_WDT_EN
    localparam int WW = $clog2(WDT_CYCLES) + 1;
    localparam logic [WW-1:0] WDT_LIM = WW'(WDT_CYCLES);

    logic [WW-1:0] wdt_q, wdt_d;
    logic          err_q, err_d;
    logic          unused_ok;

    assign unused_ok = &{1'b0, app_rdata_end, io_fifo_cmd_addr[3:0]};

    // Watchdog counts silent cycles while reads are outstanding; error is sticky.
    always_comb begin
        wdt_d = wdt_q;
        if ((outst_q == '0) || app_rdata_valid) begin
            wdt_d = '0;
        end else if (wdt_q != WDT_LIM) begin
            wdt_d = wdt_q + 1'b1;
        end
        err_d = err_q || (wdt_d == WDT_LIM);
    end

    // Watchdog registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wdt_q <= '0;
            err_q <= 1'b0;
        end else begin
            wdt_q <= wdt_d;
            err_q <= err_d;
        end
    end

    assign io_err_timeout = err_q;
`else
    logic unused_ok;

    // Without the watchdog the limit parameter has no consumer.
    assign unused_ok = &{1'b0, app_rdata_end, io_fifo_cmd_addr[3:0], (WDT_CYCLES == 0)};
    assign io_err_timeout = 1'b0;
`endif

endmodule
